branch_predict_unit: RTL

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 118 +++++++++++
 1 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Branch resolution plus a 2-bit saturating-counter branch history table.
// The fetch stage reads a prediction combinationally from registered state.
// The execute stage resolves the branch condition and trains the table.
// Optional build macro: BRANCH_STATS_EN. When it is defined, the block adds
// the saturating br_count and mispred_count statistic ports.
module branch_predict_unit #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] if_pc,
    output logic            pred_taken,
    input  logic [PC_W-1:0] ex_pc,
    input  logic            Branch,
    input  logic [2:0]      BrType,
    input  logic            Zero,
    input  logic            Neg,
    input  logic            ex_pred,
    output logic            PCSrc,
    output logic            mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
`endif
);

    localparam int DEPTH = 2 ** IDX_W;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLEZ = 3'b010;
    localparam logic [2:0] BR_BGTZ = 3'b011;
    localparam logic [2:0] BR_BLTZ = 3'b100;
    localparam logic [2:0] BR_BGEZ = 3'b101;
    localparam logic [2:0] BR_JUMP = 3'b110;

    logic [1:0]       r_bht [DEPTH];
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_cond;
    logic [1:0]       w_ex_entry;

    // Word-aligned PCs: the low two bits and the bits above the index never
    // take part in the lookup, so distinct PCs may alias to the same entry.
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];

    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0],
                                ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

    // Decode the branch condition from the ALU flags; reserved codes never take.
    always_comb begin
        w_cond = 1'b0;
        case (BrType)
            BR_BEQ:  w_cond = Zero;
            BR_BNE:  w_cond = ~Zero;
            BR_BLEZ: w_cond = Neg | Zero;
            BR_BGTZ: w_cond = ~Neg & ~Zero;
            BR_BLTZ: w_cond = Neg;
            BR_BGEZ: w_cond = ~Neg;
            BR_JUMP: w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    assign PCSrc      = Branch & w_cond;
    assign mispredict = Branch & (PCSrc ^ ex_pred);
    assign pred_taken = r_bht[w_if_idx][1];
    assign w_ex_entry = r_bht[w_ex_idx];

    // Reset every entry to weak-NT at once; otherwise train only the
    // resolving branch's entry, saturating at either end.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (Branch) begin
            if (PCSrc) begin
                if (w_ex_entry != 2'b11) begin
                    r_bht[w_ex_idx] <= w_ex_entry + 2'b01;
                end
            end else begin
                if (w_ex_entry != 2'b00) begin
                    r_bht[w_ex_idx] <= w_ex_entry - 2'b01;
                end
            end
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] r_br_count;
    logic [31:0] r_mispred_count;

    // Saturating counters of resolved branches and of wrong predictions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_count      <= 32'd0;
            r_mispred_count <= 32'd0;
        end else begin
            if (Branch && (r_br_count != 32'hFFFF_FFFF)) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (mispredict && (r_mispred_count != 32'hFFFF_FFFF)) begin
                r_mispred_count <= r_mispred_count + 32'd1;
            end
        end
    end

    assign br_count      = r_br_count;
    assign mispred_count = r_mispred_count;
`endif

endmodule
